ped_crossing_ctrl: RTL and testbench
====================================

PED_CROSSING_CTRL -- requirements
Module: ped_crossing_ctrl

Interface
REQ-001 Parameter WALK_CYCLES, default 2, steady WALK duration in clock cycles (legal 1..8).
REQ-002 Parameter FLASH_CYCLES, default 2, flashing DONT_WALK duration in clock cycles (legal 1..7; WALK_CYCLES+FLASH_CYCLES SHALL be <=15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 clear  input  1  synchronous, active-high reset.
REQ-005 RED_in, YELLOW_in, GREEN_in  input  1 each  vehicle light state from the upstream traffic-light controller, nominally one-hot.
REQ-006 ped_req  input  1  pedestrian request, level-sampled each edge.
REQ-007 WALK_out  output  1  steady walk indication.
REQ-008 DONT_WALK_out  output  1  don't-walk indication, steady or blinking.
REQ-009 ped_ack  output  1  one-cycle pulse when a request is granted.
REQ-010 fault_out  output  1  sticky light-sequence fault flag.
REQ-011 countdown  output  4  cycles remaining in crossing window.

Function
REQ-012 States SHALL be IDLE, PENDING, WALK, FLASH, FAULT; all outputs registered.
REQ-013 IDLE: ped_req=1 -> PENDING next edge.
REQ-014 PENDING: edge with RED_in=1 and registered red_prev=0 (red rising) -> WALK, ped_ack=1 for that one cycle; request arriving while red already on waits for the next red rising edge.
REQ-015 WALK SHALL last exactly WALK_CYCLES cycles, then FLASH for exactly FLASH_CYCLES cycles, then IDLE.
REQ-016 ped_req during WALK/FLASH SHALL be ignored (already served); no re-queue.
REQ-017 RED_in=0 sampled in WALK or FLASH -> PENDING next edge (abort, request retained), no ped_ack.
REQ-018 Outputs: IDLE/PENDING WALK_out=0 DONT_WALK_out=1; WALK WALK_out=1 DONT_WALK_out=0; FLASH WALK_out=0, DONT_WALK_out toggles each cycle starting at 1.
REQ-019 Light check active once red_prev/yellow_prev/green_prev valid (from second cycle after clear): fault if lights not exactly one-hot, or transition other than RED->GREEN, GREEN->YELLOW, YELLOW->RED, or hold.
REQ-020 Fault detection -> FAULT next edge from any state; FAULT sticky until clear; fault_out=1, WALK_out=0, DONT_WALK_out toggles each cycle starting at 1, ped_ack=0.
REQ-021 Fault and red rising on same edge: fault wins, no ped_ack.

Reset
REQ-022 clear=1 at edge -> IDLE, WALK_out=0, DONT_WALK_out=1, ped_ack=0, fault_out=0, countdown=0, prev-light valid flag=0, pending request discarded.
REQ-023 clear SHALL override every other input including fault and mid-WALK.

Configuration
REQ-024 Macro PED_COUNTDOWN_EN defined: countdown = WALK_CYCLES+FLASH_CYCLES on WALK entry cycle, decrements by 1 each cycle through FLASH, 0 in all other states and on abort.
REQ-025 Macro PED_COUNTDOWN_EN undefined: countdown tied to 0, counter logic absent; all other behaviour identical.

Verification
REQ-026 Defaults, normal upstream cycle R4/G4/Y2, ped_req pulse during GREEN -> ped_ack one cycle on red rising, WALK 2 cycles, DONT_WALK 1,0 in FLASH, back to IDLE before red ends.
REQ-027 ped_req during RED mid-phase -> no grant until next red rising edge; exactly one ped_ack.
REQ-028 RED_in forced 0 in first WALK cycle -> PENDING, WALK_out=0, DONT_WALK_out=1, grant on next red rising.
REQ-029 Lights RED->YELLOW, or RED=GREEN=1 -> fault_out=1 next edge, sticky through further legal cycles; clear -> IDLE, fault_out=0.
REQ-030 PED_COUNTDOWN_EN defined, defaults -> countdown 4,3,2,1 across WALK/FLASH, then 0; undefined -> countdown always 0.
REQ-031 clear asserted mid-FLASH -> next edge all outputs at reset values, later red rising with no ped_req -> no grant.

Source files
------------

// File: rtl/ped_crossing_ctrl.sv
// -----------------------------------------------------------------------------
// ped_crossing_ctrl
//   Pedestrian crossing controller that follows an upstream vehicle traffic
//   light. A pedestrian request is queued and granted on the next rising edge
//   of the vehicle red light. The crossing then shows a steady WALK, followed
//   by a blinking DONT_WALK, before returning to idle. The vehicle light
//   sequence is monitored, and any illegal pattern or transition latches a
//   sticky fault.
//
// Optional feature:
//   PED_COUNTDOWN_EN - when defined, countdown reports the number of cycles
//                      remaining in the crossing window. When undefined,
//                      countdown is tied to 0 and the counter logic is absent.
//
// Parameters:
//   WALK_CYCLES   steady WALK duration in cycles (1..8)
//   FLASH_CYCLES  blinking DONT_WALK duration in cycles (1..7);
//                 WALK_CYCLES + FLASH_CYCLES <= 15
//
// Ports:
//   clk            in   rising-edge clock
//   clear          in   synchronous active-high reset
//   RED_in         in   vehicle red light
//   YELLOW_in      in   vehicle yellow light
//   GREEN_in       in   vehicle green light
//   ped_req        in   pedestrian request (level, sampled every edge)
//   WALK_out       out  steady walk indication
//   DONT_WALK_out  out  don't-walk indication (steady or blinking)
//   ped_ack        out  one-cycle pulse when a request is granted
//   fault_out      out  sticky light-sequence fault
//   countdown[3:0] out  cycles remaining in the crossing window
// -----------------------------------------------------------------------------
module ped_crossing_ctrl #(
    parameter int WALK_CYCLES  = 2,
    parameter int FLASH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       RED_in,
    input  logic       YELLOW_in,
    input  logic       GREEN_in,
    input  logic       ped_req,
    output logic       WALK_out,
    output logic       DONT_WALK_out,
    output logic       ped_ack,
    output logic       fault_out,
    output logic [3:0] countdown
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PENDING = 3'd1,
        S_WALK    = 3'd2,
        S_FLASH   = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    // Timer holds "cycles left in this phase minus one".
    localparam logic [2:0] WALK_LOAD  = 3'(WALK_CYCLES - 1);
    localparam logic [2:0] FLASH_LOAD = 3'(FLASH_CYCLES - 1);

    // Light vectors are packed as {red, yellow, green}.
    localparam logic [2:0] L_RED    = 3'b100;
    localparam logic [2:0] L_YELLOW = 3'b010;
    localparam logic [2:0] L_GREEN  = 3'b001;

    state_t     r_state;
    logic [2:0] r_tmr;
    logic       r_walk;
    logic       r_dont_walk;
    logic       r_ack;
    logic       r_fault;
    logic [2:0] r_lights_prev;
    logic       r_prev_vld;

    state_t     w_state_nxt;
    logic [2:0] w_tmr_nxt;
    logic       w_walk_nxt;
    logic       w_dont_walk_nxt;
    logic       w_ack_nxt;
    logic       w_fault_nxt;
    logic [2:0] w_lights;
    logic       w_red_rise;
    logic       w_light_fault;

    // A light pattern is acceptable when it is one-hot and either holds or
    // advances along RED -> GREEN -> YELLOW -> RED.
    function automatic logic f_lights_ok(input logic [2:0] cur, input logic [2:0] prev);
        logic one_hot;
        logic legal_step;
        one_hot    = (cur == L_RED) || (cur == L_YELLOW) || (cur == L_GREEN);
        legal_step = (cur == prev)
                  || ((prev == L_RED)    && (cur == L_GREEN))
                  || ((prev == L_GREEN)  && (cur == L_YELLOW))
                  || ((prev == L_YELLOW) && (cur == L_RED));
        return one_hot && legal_step;
    endfunction

    assign w_lights      = {RED_in, YELLOW_in, GREEN_in};
    assign w_red_rise    = RED_in && !r_lights_prev[2];
    // Checking starts only once the previous-light register holds a real sample.
    assign w_light_fault = r_prev_vld && !f_lights_ok(w_lights, r_lights_prev);

    always_comb begin
        w_state_nxt     = r_state;
        w_tmr_nxt       = r_tmr;
        w_walk_nxt      = 1'b0;
        w_dont_walk_nxt = 1'b1;
        w_ack_nxt       = 1'b0;
        w_fault_nxt     = 1'b0;

        if (r_state == S_FAULT || w_light_fault) begin
            // A fault outranks everything, including a simultaneous red rise.
            w_state_nxt = S_FAULT;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ped_req) begin
                        w_state_nxt = S_PENDING;
                    end
                end
                S_PENDING: begin
                    if (w_red_rise) begin
                        w_state_nxt = S_WALK;
                        w_tmr_nxt   = WALK_LOAD;
                        w_ack_nxt   = 1'b1;
                    end
                end
                S_WALK: begin
                    if (!RED_in) begin
                        w_state_nxt = S_PENDING;
                    end else if (r_tmr == 3'd0) begin
                        w_state_nxt = S_FLASH;
                        w_tmr_nxt   = FLASH_LOAD;
                    end else begin
                        w_tmr_nxt = r_tmr - 3'd1;
                    end
                end
                S_FLASH: begin
                    // On the last FLASH cycle the window has fully elapsed, so
                    // red ending on that same edge completes the crossing
                    // rather than re-queuing it.
                    if (r_tmr == 3'd0) begin
                        w_state_nxt = S_IDLE;
                    end else if (!RED_in) begin
                        w_state_nxt = S_PENDING;
                    end else begin
                        w_tmr_nxt = r_tmr - 3'd1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end

        // Registered outputs are decoded from the state being entered.
        case (w_state_nxt)
            S_WALK: begin
                w_walk_nxt      = 1'b1;
                w_dont_walk_nxt = 1'b0;
            end
            S_FLASH: begin
                w_dont_walk_nxt = (r_state == S_FLASH) ? !r_dont_walk : 1'b1;
            end
            S_FAULT: begin
                w_fault_nxt     = 1'b1;
                w_dont_walk_nxt = (r_state == S_FAULT) ? !r_dont_walk : 1'b1;
            end
            default: begin
                w_dont_walk_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state       <= S_IDLE;
            r_tmr         <= 3'd0;
            r_walk        <= 1'b0;
            r_dont_walk   <= 1'b1;
            r_ack         <= 1'b0;
            r_fault       <= 1'b0;
            r_lights_prev <= 3'b000;
            r_prev_vld    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_tmr         <= w_tmr_nxt;
            r_walk        <= w_walk_nxt;
            r_dont_walk   <= w_dont_walk_nxt;
            r_ack         <= w_ack_nxt;
            r_fault       <= w_fault_nxt;
            r_lights_prev <= w_lights;
            r_prev_vld    <= 1'b1;
        end
    end

`ifdef PED_COUNTDOWN_EN
    localparam logic [3:0] CD_LOAD = 4'(WALK_CYCLES + FLASH_CYCLES);

    logic [3:0] r_countdown;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_countdown <= 4'd0;
        end else if (w_state_nxt == S_WALK && r_state != S_WALK) begin
            r_countdown <= CD_LOAD;
        end else if (w_state_nxt == S_WALK || w_state_nxt == S_FLASH) begin
            r_countdown <= r_countdown - 4'd1;
        end else begin
            r_countdown <= 4'd0;
        end
    end

    assign countdown = r_countdown;
`else
    assign countdown = 4'd0;
`endif

    assign WALK_out      = r_walk;
    assign DONT_WALK_out = r_dont_walk;
    assign ped_ack       = r_ack;
    assign fault_out     = r_fault;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ped_crossing_ctrl
//   Directed bench for ped_crossing_ctrl with default parameters. It drives a
//   linear sequence of vehicle-light cycles and pedestrian requests, and checks
//   the outputs after each relevant edge against hand-computed values.
//   Countdown expectations follow PED_COUNTDOWN_EN.
// -----------------------------------------------------------------------------
module tb_ped_crossing_ctrl;

    logic       clk = 1'b0;
    logic       clear;
    logic       RED_in;
    logic       YELLOW_in;
    logic       GREEN_in;
    logic       ped_req;
    logic       WALK_out;
    logic       DONT_WALK_out;
    logic       ped_ack;
    logic       fault_out;
    logic [3:0] countdown;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ack    = 0;

    always #5 clk = ~clk;

    ped_crossing_ctrl #(
        .WALK_CYCLES (2),
        .FLASH_CYCLES(2)
    ) dut (
        .clk          (clk),
        .clear        (clear),
        .RED_in       (RED_in),
        .YELLOW_in    (YELLOW_in),
        .GREEN_in     (GREEN_in),
        .ped_req      (ped_req),
        .WALK_out     (WALK_out),
        .DONT_WALK_out(DONT_WALK_out),
        .ped_ack      (ped_ack),
        .fault_out    (fault_out),
        .countdown    (countdown)
    );

    function automatic logic [3:0] cdv(input logic [3:0] v);
`ifdef PED_COUNTDOWN_EN
        return v;
`else
        return 4'd0;
`endif
    endfunction

    // Apply inputs, take one rising edge, then settle 1 time unit past it.
    task automatic cyc(input logic r, input logic y, input logic g, input logic req);
        RED_in    = r;
        YELLOW_in = y;
        GREEN_in  = g;
        ped_req   = req;
        @(posedge clk);
        #1;
        if (ped_ack === 1'b1) n_ack++;
    endtask

    task automatic red(input logic req); cyc(1'b1, 1'b0, 1'b0, req); endtask
    task automatic yel(input logic req); cyc(1'b0, 1'b1, 1'b0, req); endtask
    task automatic grn(input logic req); cyc(1'b0, 1'b0, 1'b1, req); endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Packed as {WALK, DONT_WALK, ack, fault, countdown[3:0]}.
    task automatic exp_out(input string tag, input logic w, input logic d,
                           input logic a, input logic f, input logic [3:0] cd);
        chk(tag, {WALK_out, DONT_WALK_out, ped_ack, fault_out, countdown},
                 {w, d, a, f, cd});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear     = 1'b1;
        RED_in    = 1'b0;
        YELLOW_in = 1'b0;
        GREEN_in  = 1'b1;
        ped_req   = 1'b0;

        // Reset.
        grn(1'b0);
        grn(1'b0);
        exp_out("reset", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        clear = 1'b0;

        // Normal cycle G4/Y2/R4 with a request during green.
        grn(1'b0);
        grn(1'b1);
        exp_out("t1_pending", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        grn(1'b0);
        grn(1'b0);
        yel(1'b0);
        yel(1'b0);
        red(1'b0);
        exp_out("t1_walk1", 1'b1, 1'b0, 1'b1, 1'b0, cdv(4'd4));
        red(1'b0);
        exp_out("t1_walk2", 1'b1, 1'b0, 1'b0, 1'b0, cdv(4'd3));
        red(1'b0);
        exp_out("t1_flash1", 1'b0, 1'b1, 1'b0, 1'b0, cdv(4'd2));
        red(1'b0);
        exp_out("t1_flash2", 1'b0, 1'b0, 1'b0, 1'b0, cdv(4'd1));
        grn(1'b0);
        exp_out("t1_idle", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

        // Request during red mid-phase waits for the next red rise.
        n_ack = 0;
        grn(1'b0);
        grn(1'b0);
        grn(1'b0);
        yel(1'b0);
        yel(1'b0);
        red(1'b0);
        exp_out("t2_red_idle", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        red(1'b1);
        exp_out("t2_pending", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        red(1'b0);
        red(1'b0);
        exp_out("t2_no_grant", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        grn(1'b0);
        grn(1'b0);
        grn(1'b0);
        grn(1'b0);
        yel(1'b0);
        yel(1'b0);
        red(1'b0);
        exp_out("t2_grant", 1'b1, 1'b0, 1'b1, 1'b0, cdv(4'd4));
        red(1'b0);
        red(1'b0);
        red(1'b0);
        grn(1'b0);
        exp_out("t2_idle", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("t2_ack_count", 8'(n_ack), 8'd1);

        // Red drops in the first WALK cycle: abort to pending, regrant later.
        grn(1'b1);
        grn(1'b0);
        grn(1'b0);
        yel(1'b0);
        yel(1'b0);
        red(1'b0);
        exp_out("t3_walk", 1'b1, 1'b0, 1'b1, 1'b0, cdv(4'd4));
        grn(1'b0);
        exp_out("t3_abort", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        grn(1'b0);
        grn(1'b0);
        exp_out("t3_hold", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        yel(1'b0);
        yel(1'b0);
        red(1'b0);
        exp_out("t3_regrant", 1'b1, 1'b0, 1'b1, 1'b0, cdv(4'd4));
        red(1'b0);
        red(1'b0);
        red(1'b0);
        grn(1'b0);
        exp_out("t3_idle", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

        // Clear in the middle of FLASH discards the crossing.
        grn(1'b1);
        yel(1'b0);
        yel(1'b0);
        red(1'b0);
        red(1'b0);
        red(1'b0);
        exp_out("t4_flash1", 1'b0, 1'b1, 1'b0, 1'b0, cdv(4'd2));
        clear = 1'b1;
        red(1'b0);
        exp_out("t4_clear", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        clear = 1'b0;
        n_ack = 0;
        red(1'b0);
        red(1'b0);
        grn(1'b0);
        grn(1'b0);
        grn(1'b0);
        grn(1'b0);
        yel(1'b0);
        yel(1'b0);
        red(1'b0);
        exp_out("t4_no_grant", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        red(1'b0);
        chk("t4_ack_count", 8'(n_ack), 8'd0);

        // RED -> YELLOW is illegal; the fault is sticky and DONT_WALK blinks.
        yel(1'b0);
        exp_out("t5_fault", 1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
        yel(1'b1);
        exp_out("t5_sticky1", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        red(1'b0);
        exp_out("t5_sticky2", 1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
        grn(1'b0);
        exp_out("t5_sticky3", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        clear = 1'b1;
        grn(1'b0);
        exp_out("t5_clear", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        clear = 1'b0;

        // RED and GREEN together are not one-hot.
        grn(1'b0);
        grn(1'b0);
        exp_out("t5b_ok", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        exp_out("t5b_fault", 1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
        red(1'b0);
        exp_out("t5b_sticky", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);

        // Fault and red rise on the same edge: fault wins, no grant.
        clear = 1'b1;
        grn(1'b0);
        clear = 1'b0;
        grn(1'b0);
        grn(1'b1);
        yel(1'b0);
        exp_out("t6_pending", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        exp_out("t6_fault_wins", 1'b0, 1'b1, 1'b0, 1'b1, 4'd0);

        // Clear overrides illegal lights; no check before prev lights are valid.
        clear = 1'b1;
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        exp_out("t7_clear", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        clear = 1'b0;
        grn(1'b0);
        exp_out("t7_first", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        grn(1'b0);
        exp_out("t7_second", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
